// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch prefetch unit.
package if_pkg;

   // Fetch control states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   // Encoding that stops the fetcher when it is read
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_0000;

   // Ceiling log2, minimum 1 so that derived vectors never collapse to zero width
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Fetch-to-decode handshake plus the redirect path coming back from EX.
interface if_prefetch_unit_if #(
   parameter int PC_SIZE = 32
);
   logic               o_valid;
   logic               i_ready;
   logic [PC_SIZE-1:0] o_instruction;
   logic [PC_SIZE-1:0] o_next_seq_pc;
   logic               i_next_pc_src;
   logic [PC_SIZE-1:0] i_next_not_seq_pc;

   modport master (
      output o_valid, o_instruction, o_next_seq_pc,
      input  i_ready, i_next_pc_src, i_next_not_seq_pc
   );

   modport slave (
      input  o_valid, o_instruction, o_next_seq_pc,
      output i_ready, i_next_pc_src, i_next_not_seq_pc
   );
endinterface

// File: rtl/if_prefetch_fifo.sv
// Small synchronous FIFO with wrap-around pointers and an occupancy count.
// Flush beats push; a push into a full FIFO only happens alongside a pop.
module if_prefetch_fifo
   import if_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_push,
   input  logic                        i_pop,
   input  logic                        i_flush,
   input  logic [WIDTH-1:0]            i_data,
   output logic [WIDTH-1:0]            o_data,
   output logic                        o_full,
   output logic                        o_empty,
   output logic [clog2(DEPTH+1)-1:0]   o_count
);
   localparam int AW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == CW'(0));
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Pointer and occupancy bookkeeping
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_rd_ptr <= AW'(0);
         r_wr_ptr <= AW'(0);
         r_count  <= CW'(0);
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents need no reset since count gates visibility
   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_flush && !i_reset) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end
endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage: loadable instruction memory, PC-driven fetcher
// and a prefetch queue presenting {instruction, PC+4} to decode.
module if_prefetch_unit
   import if_pkg::*;
#(
   parameter int                  PC_SIZE            = 32,
   parameter int                  WORD_SIZE_IN_BYTES = 4,
   parameter int                  MEM_SIZE_IN_WORDS  = 64,
   parameter int                  FIFO_DEPTH         = 4,
   parameter logic [PC_SIZE-1:0]  HALT_WORD          = PC_SIZE'(HALT_WORD_DEFAULT)
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_halt,
   input  logic                i_write_mem,
   input  logic                i_clear_mem,
   input  logic [PC_SIZE-1:0]  i_instruction,
   output logic                o_full_mem,
   output logic                o_empty_mem,
   output logic                o_halted,
   if_prefetch_unit_if.master  bus_if
);
   localparam int OFS    = clog2(WORD_SIZE_IN_BYTES) - ((WORD_SIZE_IN_BYTES == 1) ? 1 : 0);
   localparam int MEM_AW = clog2(MEM_SIZE_IN_WORDS);
   localparam int WPTR_W = clog2(MEM_SIZE_IN_WORDS + 1);
   localparam int CNT_W  = clog2(FIFO_DEPTH + 1);
   localparam logic [PC_SIZE-1:0] PC_STEP    = PC_SIZE'(WORD_SIZE_IN_BYTES);
   localparam logic [PC_SIZE-1:0] ALIGN_MASK = ~(PC_STEP - PC_SIZE'(1));

   state_e               r_state;
   state_e               w_state_next;
   logic [PC_SIZE-1:0]   r_pc;
   logic [PC_SIZE-1:0]   w_pc_next;
   logic [WPTR_W-1:0]    r_wptr;
   logic [WPTR_W-1:0]    w_wptr_next;
   logic [PC_SIZE-1:0]   r_mem [MEM_SIZE_IN_WORDS];

   logic                 w_mem_we;
   logic                 w_load_ok;
   logic                 w_active;
   logic                 w_in_range;
   logic [PC_SIZE-1:0]   w_fetch_word;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_flush;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [CNT_W-1:0]     w_fifo_count;
   logic [2*PC_SIZE-1:0] w_fifo_din;
   logic [2*PC_SIZE-1:0] w_fifo_dout;
   logic [PC_SIZE-1:0]   w_head_instr;

   assign w_load_ok    = (r_state == ST_IDLE) || (r_state == ST_HALTED);
   assign w_active     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   // Addresses at or beyond the loaded program read back as a halt
   assign w_in_range   = PC_SIZE'(r_pc >> OFS) < PC_SIZE'(r_wptr);
   assign w_fetch_word = w_in_range ? r_mem[r_pc[OFS +: MEM_AW]] : HALT_WORD;
   assign w_fifo_din   = {w_fetch_word, r_pc + PC_STEP};
   assign w_head_instr = w_fifo_dout[2*PC_SIZE-1:PC_SIZE];
   assign w_pop        = !w_fifo_empty && bus_if.i_ready;

   assign bus_if.o_valid       = !w_fifo_empty;
   assign bus_if.o_instruction = w_fifo_empty ? PC_SIZE'(0) : w_head_instr;
   assign bus_if.o_next_seq_pc = w_fifo_empty ? PC_SIZE'(0) : w_fifo_dout[PC_SIZE-1:0];
   assign o_full_mem           = (r_wptr == WPTR_W'(MEM_SIZE_IN_WORDS));
   assign o_empty_mem          = (r_wptr == WPTR_W'(0));
   assign o_halted             = (r_state == ST_HALTED);

   // Next-state, PC, write pointer and queue control; halt > redirect > start > fetch
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_wptr_next  = r_wptr;
      w_mem_we     = 1'b0;
      w_push       = 1'b0;
      w_flush      = 1'b0;

      if (w_load_ok) begin
         if (i_clear_mem) begin
            w_wptr_next = WPTR_W'(0);
         end else if (i_write_mem && !o_full_mem) begin
            w_mem_we    = 1'b1;
            w_wptr_next = r_wptr + WPTR_W'(1);
         end else begin
            w_wptr_next = r_wptr;
         end
      end else begin
         w_wptr_next = r_wptr;
      end

      if (i_halt && (r_state != ST_IDLE)) begin
         w_state_next = ST_HALTED;
         w_flush      = 1'b1;
      end else if (i_next_pc_src_q()) begin
         w_state_next = ST_RUN;
         w_flush      = 1'b1;
         w_pc_next    = bus_if.i_next_not_seq_pc & ALIGN_MASK;
      end else if (i_start && w_load_ok) begin
         w_state_next = ST_RUN;
         w_flush      = 1'b1;
         w_pc_next    = PC_SIZE'(0);
      end else begin
         case (r_state)
            ST_RUN: begin
               if (!w_fifo_full || w_pop) begin
                  w_push    = 1'b1;
                  w_pc_next = r_pc + PC_STEP;
                  if (w_fetch_word == HALT_WORD) begin
                     w_state_next = ST_DRAIN;
                  end else begin
                     w_state_next = ST_RUN;
                  end
               end else begin
                  w_state_next = ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (w_pop && (w_head_instr == HALT_WORD)) begin
                  w_state_next = ST_HALTED;
               end else begin
                  w_state_next = ST_DRAIN;
               end
            end
            default: begin
               w_state_next = r_state;
            end
         endcase
      end
   end

   // Redirects only matter while the fetcher owns the PC
   function automatic logic i_next_pc_src_q();
      return bus_if.i_next_pc_src && w_active;
   endfunction

   // Control registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_pc    <= PC_SIZE'(0);
         r_wptr  <= WPTR_W'(0);
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_wptr  <= w_wptr_next;
      end
   end

   // Program memory load port; contents survive reset
   always_ff @(posedge i_clk) begin
      if (w_mem_we && !i_reset) begin
         r_mem[r_wptr[MEM_AW-1:0]] <= i_instruction;
      end
   end

   if_prefetch_fifo #(
      .WIDTH (2 * PC_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (w_fifo_din),
      .o_data  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );
endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Parametrised next-generation instruction fetch stage for the MIPS pipeline.
- Contains:
  - a loadable instruction memory with a sequential write pointer;
  - a PC-driven fetch engine;
  - a FIFO_DEPTH-entry prefetch queue between the fetch engine and ID.
- Adds a valid/ready handshake toward ID, queue flush on branch redirect, self-detected halt with drain, and memory clear.

Parameters:
- PC_SIZE, 32, PC and instruction width in bits.
- WORD_SIZE_IN_BYTES, 4, PC increment per instruction.
- MEM_SIZE_IN_WORDS, 64, instruction memory depth.
- FIFO_DEPTH, 4, prefetch queue entries (power of two, >= 2).
- HALT_WORD, 32'h00000000, encoding treated as the halt instruction.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous active-high reset.
- i_start  in  1  begin execution at PC 0 (accepted in IDLE/HALTED only).
- i_halt  in  1  external forced halt.
- i_write_mem  in  1  write i_instruction at write pointer (IDLE/HALTED only).
- i_clear_mem  in  1  reset write pointer to 0 (IDLE/HALTED only).
- i_instruction  in  PC_SIZE  word to load.
- i_next_pc_src  in  1  redirect request from EX.
- i_next_not_seq_pc  in  PC_SIZE  redirect target (byte address).
- i_ready  in  1  ID accepts the head entry.
- o_valid  out  1  head entry valid.
- o_instruction  out  PC_SIZE  head instruction.
- o_next_seq_pc  out  PC_SIZE  head entry's PC + WORD_SIZE_IN_BYTES.
- o_full_mem  out  1  write pointer == MEM_SIZE_IN_WORDS.
- o_empty_mem  out  1  write pointer == 0.
- o_halted  out  1  unit in HALTED state.

Behaviour:
- Reset (synchronous, i_reset sampled high at edge):
  - state IDLE; write pointer 0; fetch PC 0; FIFO empty.
  - Outputs: o_valid=0, o_instruction=0, o_next_seq_pc=0, o_full_mem=0, o_empty_mem=1, o_halted=0.
  - Memory contents are preserved.
- States are IDLE, RUN, DRAIN, HALTED.
  - IDLE/HALTED --i_start--> RUN: fetch PC <= 0, FIFO flushed.
  - RUN --halt word fetched or PC out of range--> DRAIN.
  - DRAIN --halt entry popped--> HALTED.
  - Any state except IDLE --i_halt--> HALTED (FIFO flushed).
- Loading (IDLE/HALTED only):
  - i_write_mem writes mem[wptr] and increments wptr; the write is ignored when o_full_mem=1.
  - i_clear_mem sets wptr=0; if both are asserted, clear wins.
  - In RUN/DRAIN both inputs are ignored.
- Fetch engine (RUN only): each cycle the FIFO is not full (or is popped that cycle), it reads mem[PC/WORD_SIZE_IN_BYTES] (asynchronous array read), pushes {instr, PC+4} and advances PC by WORD_SIZE_IN_BYTES.
  - PC is word-aligned; the low log2(WORD_SIZE_IN_BYTES) bits of any target are ignored.
  - A word equal to HALT_WORD is pushed, then the fetcher stops and the state moves to DRAIN.
  - PC >= wptr*WORD_SIZE_IN_BYTES pushes HALT_WORD instead of reading memory (out-of-range behaves as halt).
- Latency: with i_start sampled at edge N, the first entry is pushed at edge N+1 and o_valid=1 after edge N+1. Sustained throughput is 1 instruction/cycle while i_ready=1.
- Handshake:
  - Pop occurs when o_valid&i_ready.
  - o_instruction and o_next_seq_pc are held stable while o_valid=1 and i_ready=0.
  - A push into a full FIFO is never performed; the fetcher stalls instead.
- Redirect (i_next_pc_src=1 in RUN or DRAIN):
  - FIFO flushed; PC <= target; state -> RUN.
  - o_valid=0 for the cycle after the edge; the first redirected entry is valid one cycle after that.
  - A pop in the same cycle still counts as consumed.
  - A redirect out of DRAIN cancels the pending halt.
- Priority, high to low: i_reset > i_halt > i_next_pc_src > i_start > fetch/pop.
  - i_start while RUN/DRAIN is ignored.
- Reset mid-operation returns to IDLE within one edge; no stale o_valid.
- The FIFO uses wrap-around pointers plus a count; full = count==FIFO_DEPTH, empty = count==0.

Decomposition:
- Package if_pkg:
  - state encoding constants;
  - default HALT_WORD;
  - address-width function clog2 for MEM_SIZE_IN_WORDS and FIFO_DEPTH.
- Sub-module if_prefetch_fifo:
  - parametrised width/depth synchronous FIFO with push, pop, flush, full, empty, count;
  - flush has priority over push.

Test Plan:
1. Reset, load 3 words A,B,C then HALT_WORD, i_start with i_ready=1 -> o_valid after edge N+1. Read sequence A/4, B/8, C/12, 0/16, then o_halted=1 and o_valid=0.
2. Load 64 words -> o_full_mem=1, and a 65th write leaves mem[63] unchanged. i_clear_mem -> o_empty_mem=1.
3. Run with i_ready=0 for 10 cycles -> FIFO holds FIFO_DEPTH entries and the head is stable with o_next_seq_pc=4. Release i_ready -> in-order delivery with no loss or duplication.
4. Redirect to 40 while the FIFO is full -> o_valid=0 for one cycle, then head = mem[10] with o_next_seq_pc=44.
5. i_halt mid-RUN -> o_halted=1 next cycle, FIFO empty. i_write_mem now accepted. i_start restarts at PC 0.
6. i_reset asserted during DRAIN -> all outputs at reset values after one edge. o_empty_mem reflects wptr=0.
